// File: rtl/complex_nr_acc.sv
// Block accumulator for the complex multiplier result stream: sums cfg_len+1 products
// ({re signed, im unsigned}) and presents the widened sum on a val/ready output.
module complex_nr_acc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      sw_rst,
    input  logic [LEN_WIDTH-1:0]                      cfg_len,
    input  logic                                      in_val,
    output logic                                      in_ready,
    input  logic [4*DATA_WIDTH-1:0]                   in_data,
    input  logic                                      res_ready,
    output logic                                      res_val,
    output logic [2*(2*DATA_WIDTH+LEN_WIDTH)-1:0]     res_data
);

    localparam int unsigned IW = 2 * DATA_WIDTH;
    localparam int unsigned AW = IW + LEN_WIDTH;

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e               r_state, w_state_nxt;
    logic [LEN_WIDTH:0]   r_cnt, w_cnt_nxt;
    logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
    logic [AW-1:0]        r_acc_re, w_acc_re_nxt;
    logic [AW-1:0]        r_acc_im, w_acc_im_nxt;
    logic [AW-1:0]        w_re_ext;
    logic [AW-1:0]        w_im_ext;

    // re wraps upstream so it is two's complement; im is a magnitude sum
    assign w_re_ext = {{LEN_WIDTH{in_data[4*DATA_WIDTH-1]}}, in_data[4*DATA_WIDTH-1:IW]};
    assign w_im_ext = {{LEN_WIDTH{1'b0}}, in_data[IW-1:0]};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_acc_re_nxt = r_acc_re;
        w_acc_im_nxt = r_acc_im;
        in_ready     = 1'b0;
        res_val      = 1'b0;
        res_data     = '0;

        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_val) begin
                    w_acc_re_nxt = w_re_ext;
                    w_acc_im_nxt = w_im_ext;
                    w_len_nxt    = cfg_len;
                    w_cnt_nxt    = (LEN_WIDTH+1)'(1);
                    w_state_nxt  = (cfg_len == '0) ? StOut : StAcc;
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_val) begin
                    w_acc_re_nxt = r_acc_re + w_re_ext;
                    w_acc_im_nxt = r_acc_im + w_im_ext;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    // cnt counts items already taken, so cnt==len means this is the last one
                    if (r_cnt == {1'b0, r_len}) begin
                        w_state_nxt = StOut;
                    end
                end
            end
            StOut: begin
                res_val  = 1'b1;
                res_data = {r_acc_re, r_acc_im};
                if (res_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (sw_rst) begin
            w_state_nxt  = StIdle;
            w_cnt_nxt    = '0;
            w_len_nxt    = '0;
            w_acc_re_nxt = '0;
            w_acc_im_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_len    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_acc_re <= w_acc_re_nxt;
            r_acc_im <= w_acc_im_nxt;
        end
    end

endmodule

// File: tb/tb_complex_nr_acc.sv
// Self-checking bench for complex_nr_acc: directed block scenarios plus random traffic,
// checked every cycle against a block-sum model built from plain integer arithmetic.
module tb_complex_nr_acc;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sw_rst;
    logic [3:0]  cfg_len;
    logic        in_val;
    logic        in_ready;
    logic [31:0] in_data;
    logic        res_ready;
    logic        res_val;
    logic [39:0] res_data;

    int n_total = 0;
    int n_bad   = 0;

    // model: items taken in the current block, its length, running sums, result pending
    bit m_out;
    int m_cnt;
    int m_len;
    int m_re;
    int m_im;

    complex_nr_acc #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (4)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .cfg_len   (cfg_len),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_ready (res_ready),
        .res_val   (res_val),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_out = 1'b0;
        m_cnt = 0;
        m_len = 0;
        m_re  = 0;
        m_im  = 0;
    endfunction

    task automatic check_outputs();
        logic [39:0] exp_data;
        exp_data = m_out ? {m_re[19:0], m_im[19:0]} : 40'h0;
        check("in_ready", 64'(in_ready), 64'(!m_out));
        check("res_val", 64'(res_val), 64'(m_out));
        check("res_data", 64'(res_data), 64'(exp_data));
    endtask

    task automatic model_clock();
        int re_s;
        int im_u;
        if (!rstn || sw_rst) begin
            model_reset();
        end else if (m_out) begin
            if (res_ready) m_out = 1'b0;
        end else if (in_val) begin
            re_s = int'($signed(in_data[31:16]));
            im_u = int'(in_data[15:0]);
            if (m_cnt == 0) begin
                m_len = int'(cfg_len);
                m_re  = re_s;
                m_im  = im_u;
            end else begin
                m_re += re_s;
                m_im += im_u;
            end
            m_cnt++;
            if (m_cnt == m_len + 1) begin
                m_out = 1'b1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im,
                         input logic [3:0] len, input logic rr);
        in_val    = v;
        in_data   = {re, im};
        cfg_len   = len;
        res_ready = rr;
        step();
    endtask

    task automatic clean();
        sw_rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0);
        sw_rst = 1'b0;
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_rstn();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_rst_val", 64'(res_val), 64'h0);
        #1 rstn = 1'b1;
    endtask

    initial begin
        int sr;
        int si;
        logic [15:0] a;
        logic [15:0] b;

        rstn      = 1'b0;
        sw_rst    = 1'b0;
        cfg_len   = 4'h0;
        in_val    = 1'b0;
        in_data   = 32'h0;
        res_ready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("reset_in_ready", 64'(in_ready), 64'h1);
        @(negedge clk);
        rstn = 1'b1;

        // three-item block with a negative re term
        clean();
        drive(1'b1, 16'hFFFF, 16'h0064, 4'd2, 1'b1);
        drive(1'b1, 16'h0005, 16'h00C8, 4'd2, 1'b1);
        drive(1'b1, 16'h0002, 16'h012C, 4'd2, 1'b1);
        check("t1_val", 64'(res_val), 64'h1);
        check("t1_data", 64'(res_data), 64'({20'h00006, 20'h00258}));
        drive(1'b0, 16'h0, 16'h0, 4'd2, 1'b1);
        check("t1_ready_back", 64'(in_ready), 64'h1);

        // full-length block at extreme values
        clean();
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h8000, 16'hFFFF, 4'd15, 1'b1);
        check("t2_val", 64'(res_val), 64'h1);
        check("t2_data", 64'(res_data), 64'({20'h80000, 20'hFFFF0}));

        // single-item block held by consumer backpressure
        clean();
        drive(1'b1, 16'h1234, 16'h5678, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0001, 16'h0002, 4'd0, 1'b0);
            check("t3_hold_val", 64'(res_val), 64'h1);
            check("t3_hold_data", 64'(res_data), 64'({20'h01234, 20'h05678}));
        end
        drive(1'b1, 16'h0001, 16'h0002, 4'd0, 1'b1);
        check("t3_idle", 64'(in_ready), 64'h1);
        drive(1'b1, 16'h0001, 16'h0002, 4'd0, 1'b1);
        check("t3_next_data", 64'(res_data), 64'({20'h00001, 20'h00002}));

        // gapped input, cfg_len changed after the first item
        clean();
        sr = 0;
        si = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 2 == 0) begin
                sr += int'($signed(a));
                si += int'(b);
            end
            drive(i % 2 == 0, a, b, (i == 0) ? 4'd3 : 4'd0, 1'b0);
            if (i < 6) check("t4_not_done", 64'(res_val), 64'h0);
        end
        check("t4_val", 64'(res_val), 64'h1);
        check("t4_data", 64'(res_data), 64'({sr[19:0], si[19:0]}));

        // software reset discards a partial block
        clean();
        drive(1'b1, 16'($urandom), 16'($urandom), 4'd3, 1'b1);
        drive(1'b1, 16'($urandom), 16'($urandom), 4'd3, 1'b1);
        sw_rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 4'd3, 1'b1);
        sw_rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0001, 16'h0001, 4'd3, 1'b1);
        check("t5_sw_data", 64'(res_data), 64'({20'd4, 20'd4}));

        // asynchronous reset discards a partial block, then clears a pending result
        clean();
        drive(1'b1, 16'($urandom), 16'($urandom), 4'd3, 1'b1);
        drive(1'b1, 16'($urandom), 16'($urandom), 4'd3, 1'b1);
        pulse_rstn();
        for (int i = 0; i < 4; i++) drive(1'b1, 16'h0001, 16'h0001, 4'd3, 1'b0);
        check("t5_rst_data", 64'(res_data), 64'({20'd4, 20'd4}));
        pulse_rstn();
        check("t5_rst_data0", 64'(res_data), 64'h0);

        // random traffic
        clean();
        for (int i = 0; i < 600; i++) begin
            sw_rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom),
                  1'($urandom_range(0, 1)));
        end
        sw_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
